// File: rtl/procesador_fifo_st_to_mm.sv
`default_nettype none
// ============================================================================
//  Module   : procesador_fifo_st_to_mm
//  Purpose  : Streaming-sink to memory-mapped-slave FIFO. Words arriving on
//             the stream sink are buffered in an inferred simple dual-port RAM.
//             A host drains, monitors and controls the buffer over a small
//             register window.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    DATA_W      stream word width (1..32)
//    DEPTH_LOG2  log2 of FIFO depth in words (4..14)
//  Ports
//    wrclock                   sole clock, rising edge
//    reset                     asynchronous, active-high
//    avalonst_sink_data/valid  stream word and its qualifier
//    avalonst_sink_ready       space available (ready latency 0)
//    avalonmm_slave_address    0: pop data, 1: level, 2: status/control,
//                              3: irq threshold (when enabled)
//    avalonmm_slave_read/write strobes; writedata is 32 bits
//    avalonmm_slave_readdata   registered read data, latency 1
//    irq                       level interrupt (FIFO_ST_MM_LEVEL_IRQ_EN only)
//  Build options
//    FIFO_ST_MM_LEVEL_IRQ_EN   adds the threshold register and irq output
// ============================================================================
module procesador_fifo_st_to_mm #(
    parameter int DATA_W     = 32,
    parameter int DEPTH_LOG2 = 11
) (
    input  logic              wrclock,
    input  logic              reset,
    input  logic [DATA_W-1:0] avalonst_sink_data,
    input  logic              avalonst_sink_valid,
    output logic              avalonst_sink_ready,
    input  logic [1:0]        avalonmm_slave_address,
    input  logic              avalonmm_slave_read,
    input  logic              avalonmm_slave_write,
    input  logic [31:0]       avalonmm_slave_writedata,
    output logic [31:0]       avalonmm_slave_readdata
`ifdef FIFO_ST_MM_LEVEL_IRQ_EN
    ,
    output logic              irq
`endif
);

    localparam int c_DEPTH = 1 << DEPTH_LOG2;

    logic [DATA_W-1:0]     r_mem [0:c_DEPTH-1];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_level;
    logic                  r_overflow;
    logic                  r_underflow;
    logic [15:0]           r_drop_count;
    logic [31:0]           r_readdata;

    logic w_full;
    logic w_empty;
    logic w_pop_req;
    logic w_pop;
    logic w_ready;
    logic w_push;
    logic w_drop;
    logic w_ctrl_wr;
    logic w_flush;
    logic w_clear;
    logic w_unused;

    // Level never exceeds the depth, so its MSB alone marks "full".
    assign w_full    = r_level[DEPTH_LOG2];
    assign w_empty   = (r_level == '0);
    assign w_pop_req = avalonmm_slave_read && (avalonmm_slave_address == 2'd0);
    assign w_pop     = w_pop_req && !w_empty;

    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign w_ready             = !w_full || w_pop;
    assign avalonst_sink_ready = w_ready;

    assign w_ctrl_wr = avalonmm_slave_write && (avalonmm_slave_address == 2'd2);
    assign w_flush   = w_ctrl_wr && avalonmm_slave_writedata[0];
    assign w_clear   = w_ctrl_wr && avalonmm_slave_writedata[1];

    // A word accepted during a flush is discarded silently (not a drop).
    assign w_push = avalonst_sink_valid && w_ready && !w_flush;
    assign w_drop = avalonst_sink_valid && !w_ready;

    assign w_unused = &{1'b0, avalonmm_slave_writedata};

    // Storage: no reset so the array maps onto block RAM. The read port is
    // sampled into readdata below, giving read-old-data on a shared address.
    always_ff @(posedge wrclock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= avalonst_sink_data;
        end
    end

    always_ff @(posedge wrclock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + 1'b1;
            end else if (w_pop && !w_push) begin
                r_level <= r_level - 1'b1;
            end
        end
    end

    // Sticky flags and drop counter; a clear request wins over a same-cycle event.
    always_ff @(posedge wrclock or posedge reset) begin
        if (reset) begin
            r_overflow   <= 1'b0;
            r_underflow  <= 1'b0;
            r_drop_count <= '0;
        end else if (w_clear) begin
            r_overflow   <= 1'b0;
            r_underflow  <= 1'b0;
            r_drop_count <= '0;
        end else begin
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_count != 16'hFFFF) begin
                    r_drop_count <= r_drop_count + 1'b1;
                end
            end
            if (w_pop_req && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

`ifdef FIFO_ST_MM_LEVEL_IRQ_EN
    logic [DEPTH_LOG2:0] r_threshold;
    logic                r_irq;

    always_ff @(posedge wrclock or posedge reset) begin
        if (reset) begin
            r_threshold <= '0;
            r_irq       <= 1'b0;
        end else begin
            if (avalonmm_slave_write && (avalonmm_slave_address == 2'd3)) begin
                r_threshold <= avalonmm_slave_writedata[DEPTH_LOG2:0];
            end
            // A zero threshold disables the interrupt.
            r_irq <= (r_threshold != '0) && (r_level >= r_threshold);
        end
    end

    assign irq = r_irq;
`endif

    // Register window: readdata only changes on a read, otherwise it holds.
    always_ff @(posedge wrclock or posedge reset) begin
        if (reset) begin
            r_readdata <= '0;
        end else if (avalonmm_slave_read) begin
            case (avalonmm_slave_address)
                2'd0: r_readdata <= w_empty ? 32'd0 : 32'(r_mem[r_rd_ptr]);
                2'd1: r_readdata <= 32'(r_level);
                2'd2: r_readdata <= {r_drop_count, 12'd0, r_underflow,
                                     r_overflow, w_full, w_empty};
`ifdef FIFO_ST_MM_LEVEL_IRQ_EN
                default: r_readdata <= 32'(r_threshold);
`else
                default: r_readdata <= 32'd0;
`endif
            endcase
        end
    end

    assign avalonmm_slave_readdata = r_readdata;

endmodule
`default_nettype wire

// File: doc/procesador_fifo_st_to_mm.md
PROCESADOR_FIFO_ST_TO_MM -- requirements
Module: procesador_fifo_st_to_mm

Interface
REQ-001 SHALL have parameter DATA_W, default 32, stream word width (legal 1..32).
REQ-002 SHALL have parameter DEPTH_LOG2, default 11, FIFO depth = 2**DEPTH_LOG2 words (legal 4..14).
REQ-003 SHALL have port wrclock  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port avalonst_sink_data  input  DATA_W  stream word.
REQ-006 SHALL have port avalonst_sink_valid  input  1  stream word present.
REQ-007 SHALL have port avalonst_sink_ready  output  1  space available, ready latency 0.
REQ-008 SHALL have port avalonmm_slave_address  input  2  word address.
REQ-009 SHALL have port avalonmm_slave_read  input  1  read strobe.
REQ-010 SHALL have port avalonmm_slave_write  input  1  write strobe.
REQ-011 SHALL have port avalonmm_slave_writedata  input  32  write data.
REQ-012 SHALL have port avalonmm_slave_readdata  output  32  registered read data, fixed latency 1.
REQ-013 SHALL have port irq  output  1  level interrupt (present only with FIFO_ST_MM_LEVEL_IRQ_EN).

Function
REQ-014 SHALL store words in an inferred simple dual-port RAM of 2**DEPTH_LOG2 x DATA_W with wrapping read/write pointers and a DEPTH_LOG2+1 bit level counter.
REQ-015 SHALL drive avalonst_sink_ready = !full | pop, where pop = read && address==0 && !empty.
REQ-016 SHALL push on valid && ready; valid && !ready SHALL drop the word, set overflow sticky, increment 16-bit drop counter (saturating at 0xFFFF).
REQ-017 Read address 0: SHALL pop head word, readdata = zero-extended word on the next cycle; when empty SHALL return 0, leave pointers unchanged, set underflow sticky.
REQ-018 Read address 1: SHALL return level, zero-extended.
REQ-019 Read address 2: SHALL return {drop_count[15:0], 12'b0, underflow, overflow, full, empty}.
REQ-020 Write address 2: bit0=1 SHALL flush (pointers and level to 0 next cycle, any push that cycle discarded and not counted); bit1=1 SHALL clear overflow, underflow, drop counter.
REQ-021 Simultaneous push and pop SHALL leave level unchanged; when full both SHALL succeed; when empty the push SHALL succeed and the pop returns 0 with underflow (no bypass).
REQ-022 readdata SHALL hold its last value on cycles without read.
REQ-023 Writes to address 0/1 SHALL be ignored; level SHALL never exceed 2**DEPTH_LOG2.

Reset
REQ-024 reset SHALL asynchronously clear pointers, level, stickies, drop counter, readdata (0), irq (0), threshold (0); avalonst_sink_ready SHALL be 1 while reset is high; RAM contents need not be cleared.
REQ-025 Reset mid-transfer SHALL abort any pending read; first read after release returns per REQ-017 on the empty FIFO.

Configuration
REQ-026 With FIFO_ST_MM_LEVEL_IRQ_EN defined: address 3 SHALL be a read/write threshold register (DEPTH_LOG2+1 bits, zero-extended) and irq SHALL be registered, 1 when level >= threshold and threshold != 0.
REQ-027 Without FIFO_ST_MM_LEVEL_IRQ_EN: irq port, threshold register and comparator SHALL be absent; address 3 reads 0, writes ignored.

Verification
REQ-028 Push 0x11,0x22,0x33; read addr0 three times -> readdata 0x11,0x22,0x33 each one cycle after the read; addr1 then reads 0.
REQ-029 DEPTH_LOG2=4: push 18 words with valid held -> ready falls after 16, level=16, status=0x0002_0006 (drop=2, overflow, full).
REQ-030 Full FIFO, simultaneous push 0xAA and pop -> ready=1, level stays 16, 0xAA read out as 16th subsequent word.
REQ-031 Empty FIFO, read addr0 -> readdata 0, status bit3=1; write 0x2 to addr2 -> status 0x0000_0001.
REQ-032 Push 5 words, write 0x1 to addr2 with valid high that cycle -> level 0, empty=1, drop counter 0.
REQ-033 With FIFO_ST_MM_LEVEL_IRQ_EN, threshold=4: push 4 words -> irq=1 one cycle after 4th push; pop 1 -> irq=0; assert reset -> irq=0, ready=1 immediately.
